alureg_seq: RTL and testbench

Fetch/decode/execute sequencer for the alureg register/ALU datapath. Fetches opcode bytes over a simple memory read handshake and keeps its own program counter. Generates the datapath strobes: instruction load (enc), temp-data load (end), register read (rrd) and register write (rwr). Handles the register-move/halt group (01) and basic-ALU group (10); groups 00 and 11 are flagged illegal and skipped.

---
 rtl/alureg_seq_pkg.sv | 41 ++++
 rtl/alureg_seq_if.sv | 30 +++
 rtl/alureg_dec.sv | 46 ++++
 rtl/alureg_seq.sv | 111 +++++++++++
 tb/tb_alureg_seq.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/alureg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alureg_seq_pkg
// Purpose : Shared state encodings and opcode field constants for the
//           alureg fetch/decode/execute sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package alureg_seq_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_OPRD   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } seqState_t;

   localparam int          c_OP_W    = 8;

   localparam logic [1:0]  c_GRP_TA  = 2'b00;
   localparam logic [1:0]  c_GRP_MV  = 2'b01;
   localparam logic [1:0]  c_GRP_AL  = 2'b10;
   localparam logic [1:0]  c_GRP_SC  = 2'b11;

   localparam logic [7:0]  c_OP_HLT  = 8'h76;
   localparam logic [2:0]  c_SRC_MEM = 3'b110;

   function automatic logic [1:0] opGroup(input logic [c_OP_W-1:0] op);
      return op[7:6];
   endfunction

   function automatic logic [2:0] opDst(input logic [c_OP_W-1:0] op);
      return op[5:3];
   endfunction

   function automatic logic [2:0] opSrc(input logic [c_OP_W-1:0] op);
      return op[2:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/alureg_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : alureg_seq_if
// Purpose : Memory read handshake between the sequencer and program memory.
// Revision: 1.0 - initial release
// ============================================================================
interface alureg_seq_if #(
   parameter int PCSIZE   = 16,
   parameter int DATASIZE = 8
);
   logic                mem_req;
   logic [PCSIZE-1:0]   mem_addr;
   logic                mem_ack;
   logic [DATASIZE-1:0] mem_dat;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_dat
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_dat
   );
endinterface
`default_nettype wire

// File: rtl/alureg_dec.sv
`default_nettype none
// ============================================================================
// Module  : alureg_dec
// Purpose : Combinational opcode classifier: halt, illegal, immediate operand.
// Revision: 1.0 - initial release
// ============================================================================
module alureg_dec
   import alureg_seq_pkg::*;
(
   input  wire logic [c_OP_W-1:0] opCode,
   output logic                   is_hlt,
   output logic                   is_ill,
   output logic                   need_imm
);

   logic [1:0] w_grp;
   logic [2:0] w_dst;
   logic [2:0] w_src;

   assign w_grp = opGroup(opCode);
   assign w_dst = opDst(opCode);
   assign w_src = opSrc(opCode);

   always_comb begin
      is_hlt   = 1'b0;
      is_ill   = 1'b0;
      need_imm = 1'b0;
      // HLT sits inside the move group's store-to-memory slot, so it wins first
      if (opCode == c_OP_HLT) begin
         is_hlt = 1'b1;
      end else begin
         case (w_grp)
            c_GRP_MV: begin
               if (w_dst == c_SRC_MEM) is_ill = 1'b1;
               else                    need_imm = (w_src == c_SRC_MEM);
            end
            c_GRP_AL: need_imm = (w_src == c_SRC_MEM);
            c_GRP_TA,
            c_GRP_SC: is_ill = 1'b1;
            default:  is_ill = 1'b1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/alureg_seq.sv
`default_nettype none
// ============================================================================
// Module  : alureg_seq
// Purpose : Fetch/decode/execute sequencer generating alureg datapath strobes.
// Revision: 1.0 - initial release
// ============================================================================
module alureg_seq
   import alureg_seq_pkg::*;
#(
   parameter int                 PCSIZE   = 16,
   parameter int                 DATASIZE = 8,
   parameter logic [PCSIZE-1:0]  RESET_PC = '0
)(
   input  wire logic                clk,
   input  wire logic                rst,
   alureg_seq_if.master             bus,
   output logic                     o_enc,
   output logic                     o_end,
   output logic                     o_rrd,
   output logic                     o_rwr,
   output logic [DATASIZE-1:0]      o_dat,
   output logic                     o_hlt,
   output logic                     o_ill,
   input  wire logic                i_run
);

   seqState_t           r_state;
   seqState_t           w_nextState;
   logic [PCSIZE-1:0]   r_pc;
   logic [c_OP_W-1:0]   r_opCode;

   logic                w_isHlt;
   logic                w_isIll;
   logic                w_needImm;
   logic                w_fetchAck;
   logic                w_immAck;

   alureg_dec u_dec (
      .opCode   (r_opCode),
      .is_hlt   (w_isHlt),
      .is_ill   (w_isIll),
      .need_imm (w_needImm)
   );

   // Reset gating keeps a stray ack from producing a strobe while rst is high
   assign w_fetchAck = (r_state == ST_FETCH) && bus.mem_ack && !rst;
   assign w_immAck   = (r_state == ST_OPRD)  && bus.mem_ack && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_FETCH;
         r_pc     <= RESET_PC;
         r_opCode <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_fetchAck) begin
            r_opCode <= bus.mem_dat[c_OP_W-1:0];
            r_pc     <= r_pc + 1'b1;
         end else if (w_immAck) begin
            r_pc     <= r_pc + 1'b1;
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      o_enc       = 1'b0;
      o_end       = 1'b0;
      o_rrd       = 1'b0;
      o_rwr       = 1'b0;
      o_hlt       = 1'b0;
      o_ill       = 1'b0;
      bus.mem_req = 1'b0;
      case (r_state)
         ST_FETCH: begin
            bus.mem_req = 1'b1;
            o_enc       = w_fetchAck;
            if (w_fetchAck) w_nextState = ST_DECODE;
         end
         ST_DECODE: begin
            if (w_isHlt)        w_nextState = ST_HALT;
            else if (w_isIll) begin
               o_ill       = !rst;
               w_nextState = ST_FETCH;
            end
            else if (w_needImm) w_nextState = ST_OPRD;
            else                w_nextState = ST_EXEC;
         end
         ST_OPRD: begin
            bus.mem_req = 1'b1;
            o_end       = w_immAck;
            if (w_immAck) w_nextState = ST_EXEC;
         end
         ST_EXEC: begin
            o_rrd       = !rst;
            o_rwr       = !rst;
            w_nextState = ST_FETCH;
         end
         ST_HALT: begin
            o_hlt = !rst;
            if (i_run) w_nextState = ST_FETCH;
         end
         default: w_nextState = ST_FETCH;
      endcase
   end

   assign bus.mem_addr = r_pc;
   assign o_dat        = bus.mem_dat;

endmodule
`default_nettype wire

// File: tb/tb_alureg_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alureg_seq
// Purpose : Directed self-checking bench for the alureg sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alureg_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;

   int nTests = 0;
   int nFail  = 0;

   alureg_seq_if #(.PCSIZE(16), .DATASIZE(8)) bus  ();
   alureg_seq_if #(.PCSIZE(16), .DATASIZE(8)) bus2 ();

   logic       enc, endS, rrd, rwr, hlt, ill;
   logic [7:0] dat;
   logic       enc2, end2, rrd2, rwr2, hlt2, ill2;
   logic [7:0] dat2;

   alureg_seq #(.PCSIZE(16), .DATASIZE(8), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .o_enc(enc), .o_end(endS), .o_rrd(rrd), .o_rwr(rwr),
      .o_dat(dat), .o_hlt(hlt), .o_ill(ill), .i_run(run)
   );

   // Second instance starts at the top of the address space for the wrap check
   alureg_seq #(.PCSIZE(16), .DATASIZE(8), .RESET_PC(16'hFFFF)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2),
      .o_enc(enc2), .o_end(end2), .o_rrd(rrd2), .o_rwr(rwr2),
      .o_dat(dat2), .o_hlt(hlt2), .o_ill(ill2), .i_run(1'b0)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.mem_ack  = 1'b0; bus.mem_dat  = 8'hA5;
      bus2.mem_ack = 1'b0; bus2.mem_dat = 8'h00;

      // Reset state
      tick(); tick();
      chk("rst_req",  {31'd0, bus.mem_req}, 1);
      chk("rst_addr", {16'd0, bus.mem_addr}, 32'h0);
      chk("rst_strb", {26'd0, enc, endS, rrd, rwr, hlt, ill}, 0);
      chk("rst_dat",  {24'd0, dat}, 32'hA5);
      rst = 1'b0;

      // MOV A,B zero-wait: FETCH, DECODE, EXEC
      bus.mem_dat = 8'h78; bus.mem_ack = 1'b1; #1;
      chk("mov_enc", {31'd0, enc}, 1);
      tick(); bus.mem_ack = 1'b0; #1;
      chk("mov_dec", {27'd0, enc, bus.mem_req, rrd, rwr, ill}, 0);
      tick(); bus.mem_ack = 1'b1; #1;
      chk("mov_exec", {28'd0, rrd, rwr, enc, bus.mem_req}, 32'b1100);
      bus.mem_ack = 1'b0;
      tick();
      chk("mov_next", {15'd0, bus.mem_req, bus.mem_addr}, {15'd0, 1'b1, 16'h0001});

      // ADD A,imm with two wait states on each read
      bus.mem_dat = 8'h86;
      tick(); tick();
      chk("imm_wait", {31'd0, enc}, 0);
      bus.mem_ack = 1'b1; #1;
      chk("imm_enc", {30'd0, enc, endS}, 32'b10);
      tick(); bus.mem_ack = 1'b0;
      tick();
      chk("oprd_req", {15'd0, bus.mem_req, bus.mem_addr}, {15'd0, 1'b1, 16'h0002});
      tick(); tick();
      chk("oprd_wait", {31'd0, endS}, 0);
      bus.mem_dat = 8'h05; bus.mem_ack = 1'b1; #1;
      chk("imm_end", {22'd0, enc, endS, dat}, {22'd0, 2'b01, 8'h05});
      tick(); bus.mem_ack = 1'b0; #1;
      chk("imm_exec", {30'd0, rrd, rwr}, 32'b11);
      tick();
      chk("imm_next", {16'd0, bus.mem_addr}, 32'h0003);

      // HLT; i_run during DECODE must be ignored
      bus.mem_dat = 8'h76; bus.mem_ack = 1'b1;
      tick(); bus.mem_ack = 1'b0; run = 1'b1; #1;
      chk("hlt_dec", {31'd0, hlt}, 0);
      tick(); run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("hlt_hold", {30'd0, hlt, bus.mem_req}, 32'b10);
         tick();
      end
      run = 1'b1;
      tick(); run = 1'b0;
      chk("hlt_resume", {14'd0, hlt, bus.mem_req, bus.mem_addr}, {14'd0, 2'b01, 16'h0004});

      // Illegal opcodes: group 00 and store-to-memory move
      bus.mem_dat = 8'h3E; bus.mem_ack = 1'b1;
      tick(); bus.mem_ack = 1'b0; #1;
      chk("ill_ta", {29'd0, ill, rrd, rwr}, 32'b100);
      tick();
      chk("ill_ta_next", {15'd0, ill, bus.mem_addr}, {15'd0, 1'b0, 16'h0005});
      bus.mem_dat = 8'h70; bus.mem_ack = 1'b1;
      tick(); bus.mem_ack = 1'b0; #1;
      chk("ill_mv", {29'd0, ill, rrd, rwr}, 32'b100);
      tick();
      chk("ill_mv_next", {13'd0, ill, rrd, rwr, bus.mem_addr}, {13'd0, 3'b000, 16'h0006});

      // PC wrap on the second instance
      chk("wrap_start", {16'd0, bus2.mem_addr}, 32'hFFFF);
      bus2.mem_dat = 8'h47; bus2.mem_ack = 1'b1; #1;
      chk("wrap_enc", {31'd0, enc2}, 1);
      tick(); bus2.mem_ack = 1'b0; #1;
      chk("wrap_addr", {16'd0, bus2.mem_addr}, 32'h0000);
      tick(); tick();
      chk("wrap_fetch", {15'd0, bus2.mem_req, bus2.mem_addr}, {15'd0, 1'b1, 16'h0000});

      // Reset while an immediate read is pending
      bus.mem_dat = 8'h46; bus.mem_ack = 1'b1;
      tick(); bus.mem_ack = 1'b0;
      tick();
      chk("abort_oprd", {15'd0, bus.mem_req, bus.mem_addr}, {15'd0, 1'b1, 16'h0007});
      bus.mem_dat = 8'h55; bus.mem_ack = 1'b1; #1;
      chk("abort_pre", {31'd0, endS}, 1);
      rst = 1'b1; #1;
      chk("abort_strb", {26'd0, enc, endS, rrd, rwr, hlt, ill}, 0);
      chk("abort_addr", {15'd0, bus.mem_req, bus.mem_addr}, {15'd0, 1'b1, 16'h0000});
      tick(); bus.mem_ack = 1'b0; rst = 1'b0;
      tick();
      chk("abort_idle", {14'd0, enc, bus.mem_req, bus.mem_addr}, {14'd0, 2'b01, 16'h0000});
      bus.mem_dat = 8'h78; bus.mem_ack = 1'b1; #1;
      chk("abort_refetch", {31'd0, enc}, 1);
      tick(); bus.mem_ack = 1'b0; #1;
      chk("abort_pc", {16'd0, bus.mem_addr}, 32'h0001);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
`default_nettype wire
